// File: rtl/pc_pkg.sv
// pc_pkg: shared constants, state encoding and alignment helper for the PC stage
package pc_pkg;
  localparam int XLEN = 64;
  localparam int STEP = 4;
  localparam logic [63:0] RESET_PC = 64'h0;
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  function automatic logic is_aligned(input logic [1:0] lo);
    return lo == 2'b00;
  endfunction
endpackage

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter with fetch handshake, redirects, misaligned trap and fetch counter
module pc_fetch_unit
  import pc_pkg::*;
#(
  parameter int XLEN = pc_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = pc_pkg::RESET_PC[XLEN-1:0],
  parameter int STEP = pc_pkg::STEP
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] pc_plus_step,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] pc_out,
  output logic            fetch_valid,
  output logic            misaligned_trap,
  output logic [XLEN-1:0] trap_addr,
  output logic [31:0]     fetch_count
);
  // The external adder only ever produces aligned successors if the step keeps word alignment
  if (STEP % 4 != 0) begin : g_step_chk
    $error("STEP must be a multiple of 4");
  end
  state_t state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, trap_addr_q, trap_addr_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic fetch_valid_q, trap_q, trap_d;
  // Next-state decode: stall freezes RUN, a misaligned redirect traps into HALT, HALT is terminal
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    fetch_count_d = fetch_count_q;
    trap_d = trap_q;
    trap_addr_d = trap_addr_q;
    if (state_q == BOOT) state_d = RUN;
    else if (state_q == RUN && !stall) begin
      if (branch_taken && !is_aligned(branch_target[1:0])) begin
        state_d = HALT;
        trap_d = 1'b1;
        trap_addr_d = branch_target;
      end else begin
        pc_d = branch_taken ? branch_target : fetch_ready ? pc_plus_step : pc_q;
        fetch_count_d = fetch_ready ? fetch_count_q + 32'd1 : fetch_count_q;
      end
    end
  end
  // State and registered outputs; fetch_valid is a registered decode of the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q <= RESET_PC;
      fetch_valid_q <= 1'b0;
      trap_q <= 1'b0;
      trap_addr_q <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      fetch_valid_q <= state_d == RUN;
      trap_q <= trap_d;
      trap_addr_q <= trap_addr_d;
      fetch_count_q <= fetch_count_d;
    end
  end
  assign pc_out = pc_q;
  assign fetch_valid = fetch_valid_q;
  assign misaligned_trap = trap_q;
  assign trap_addr = trap_addr_q;
  assign fetch_count = fetch_count_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed and randomized checks of pc_fetch_unit against a behavioural model
module tb_pc_fetch_unit;
  localparam logic [63:0] RPC = 64'h1000;
  logic clk = 0, reset = 1, stall = 0, branch_taken = 0, fetch_ready = 0;
  logic [63:0] branch_target = 0, pc_plus_step, pc_out, trap_addr;
  logic fetch_valid, misaligned_trap;
  logic [31:0] fetch_count;
  int passed = 0, total = 0;
  // model: phase 0 = just out of reset, 1 = fetching, 2 = trapped
  int m_phase;
  logic [63:0] m_pc, m_taddr;
  logic m_trap;
  logic [31:0] m_cnt;

  pc_fetch_unit #(.XLEN(64), .RESET_PC(RPC), .STEP(4)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .pc_plus_step(pc_plus_step), .fetch_ready(fetch_ready),
    .pc_out(pc_out), .fetch_valid(fetch_valid), .misaligned_trap(misaligned_trap),
    .trap_addr(trap_addr), .fetch_count(fetch_count)
  );

  assign pc_plus_step = pc_out + 64'd4;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".pc"}, pc_out, m_pc);
    chk({tag, ".valid"}, {63'd0, fetch_valid}, {63'd0, m_phase == 1});
    chk({tag, ".trap"}, {63'd0, misaligned_trap}, {63'd0, m_trap});
    chk({tag, ".taddr"}, trap_addr, m_taddr);
    chk({tag, ".cnt"}, {32'd0, fetch_count}, {32'd0, m_cnt});
  endtask

  task automatic model_reset();
    m_phase = 0; m_pc = RPC; m_taddr = 0; m_trap = 0; m_cnt = 0;
  endtask

  // one clock: advance the model from current inputs, take the edge, then compare
  task automatic step(input string tag);
    if (m_phase == 0) m_phase = 1;
    else if (m_phase == 1 && !stall) begin
      if (branch_taken && branch_target[1:0] != 0) begin
        m_phase = 2; m_trap = 1; m_taddr = branch_target;
      end else begin
        if (branch_taken) m_pc = branch_target;
        else if (fetch_ready) m_pc = m_pc + 4;
        if (fetch_ready) m_cnt = m_cnt + 1;
      end
    end
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  task automatic drive(input logic s, input logic b, input logic [63:0] t, input logic r);
    stall = s; branch_taken = b; branch_target = t; fetch_ready = r;
  endtask

  initial begin
    model_reset();
    #12;
    chk_all("reset");
    @(negedge clk);
    reset = 0;
    drive(0, 0, 0, 1);
    step("boot");
    step("seq1");
    step("seq2");
    step("seq3");
    chk("cnt3", {32'd0, fetch_count}, 64'd3);
    chk("pc100c", pc_out, 64'h100c);
    drive(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("hold");
    drive(0, 0, 0, 1);
    step("resume");
    drive(1, 1, 64'h2000, 1);
    step("stall_br");
    step("stall_br2");
    drive(0, 1, 64'h2000, 1);
    step("br");
    chk("br2000", pc_out, 64'h2000);
    drive(0, 1, 64'h3000, 0);
    step("br_nordy");
    drive(0, 1, 64'h2002, 1);
    step("mis");
    chk("mis_taddr", trap_addr, 64'h2002);
    drive(0, 1, 64'h4000, 1);
    step("halt1");
    drive(0, 0, 0, 1);
    step("halt2");
    #3;
    reset = 1;
    #1;
    model_reset();
    chk_all("async_rst");
    @(negedge clk);
    reset = 0;
    step("reboot");
    step("reboot_run");
    // wrap: preload the counter while stalled
    drive(1, 0, 0, 1);
    @(negedge clk);
    force dut.fetch_count_q = 32'hFFFF_FFFE;
    @(posedge clk);
    #1;
    release dut.fetch_count_q;
    m_cnt = 32'hFFFF_FFFE;
    drive(0, 0, 0, 1);
    step("pre_wrap");
    step("wrap");
    chk("wrap0", {32'd0, fetch_count}, 64'd0);
    // randomized traffic, resetting whenever the model traps
    for (int i = 0; i < 400; i++) begin
      logic [63:0] t;
      t = {32'd0, $urandom} & ~64'h3;
      if ($urandom_range(0, 39) == 0) t[1:0] = 2'($urandom_range(1, 3));
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, t, $urandom_range(0, 2) != 0);
      step("rand");
      if (m_phase == 2 && $urandom_range(0, 3) == 0) begin
        #2;
        reset = 1;
        #1;
        model_reset();
        chk_all("rand_rst");
        @(negedge clk);
        reset = 0;
      end
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
